alu_exec_stage: RTL and testbench

- Registered execute-stage ALU for the 5-stage pipelined RISC-V core.
- Consumes the 3-bit ALUControl code produced by the ALU decoder, together with two operands, and returns result and Zero flag.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stalls from MEM do not create a combinational ready path back into ID/EX.
- Counts illegal control codes for debug.

---
 rtl/alu_exec_pkg.sv | 28 ++
 rtl/alu_core.sv | 58 +++++
 rtl/alu_exec_stage.sv | 102 ++++++++++
 tb/tb_alu_exec_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types for the execute-stage ALU.
// ALU_EXEC_FLAGS_EN adds carry/overflow bits to the buffered metadata.
package alu_exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // zero/negative are derived from the stored result, so only these travel
    typedef struct packed {
        logic illegal;
`ifdef ALU_EXEC_FLAGS_EN
        logic carry;
        logic overflow;
`endif
    } alu_meta_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: ADD/SUB/AND/OR/SLT, illegal codes give 0.
// ALU_EXEC_FLAGS_EN adds carry (not-borrow on SUB) and signed overflow.
module alu_core import alu_exec_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output alu_meta_t        meta
);

    logic lt;

`ifdef ALU_EXEC_FLAGS_EN
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
`else
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;
`endif

    assign lt = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        meta   = '0;
        unique case (ctrl)
            ALU_ADD: begin
                result = sum[WIDTH-1:0];
`ifdef ALU_EXEC_FLAGS_EN
                meta.carry    = sum[WIDTH];
                meta.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                                (sum[WIDTH-1] != a[WIDTH-1]);
`endif
            end
            ALU_SUB: begin
                result = diff[WIDTH-1:0];
`ifdef ALU_EXEC_FLAGS_EN
                meta.carry    = ~diff[WIDTH];
                meta.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                                (diff[WIDTH-1] != a[WIDTH-1]);
`endif
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default: meta.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU with 2-entry skid buffer and illegal counter.
// ALU_EXEC_FLAGS_EN adds out_carry/out_overflow/out_negative.
module alu_exec_stage import alu_exec_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_alu_control,
    input  logic [WIDTH-1:0]    in_src_a,
    input  logic [WIDTH-1:0]    in_src_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                out_zero,
    output logic                out_illegal,
    output logic [ERRCNT_W-1:0] err_count
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic                out_carry,
    output logic                out_overflow,
    output logic                out_negative
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_meta_t        meta;
    } alu_res_t;

    buf_state_e       state;
    alu_res_t         main_q;
    alu_res_t         skid_q;
    alu_res_t         core_res;
    logic [WIDTH-1:0] core_result;
    alu_meta_t        core_meta;
    logic             push;
    logic             pop;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .ctrl   (in_alu_control),
        .a      (in_src_a),
        .b      (in_src_b),
        .result (core_result),
        .meta   (core_meta)
    );

    assign core_res  = {core_result, core_meta};
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result  = main_q.result;
    assign out_zero    = (main_q.result == '0);
    assign out_illegal = main_q.meta.illegal;
`ifdef ALU_EXEC_FLAGS_EN
    assign out_carry    = main_q.meta.carry;
    assign out_overflow = main_q.meta.overflow;
    assign out_negative = main_q.result[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            err_count <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= core_res;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= core_res;
                    end else if (push) begin
                        skid_q <= core_res;
                        state  <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (push && core_meta.illegal && err_count != '1)
                err_count <= err_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized + directed bench for alu_exec_stage against a queue model.
// Define ALU_EXEC_FLAGS_EN to also exercise the flag outputs.
module tb_alu_exec_stage;

    localparam int W   = 32;
    localparam int EW  = 2;
    localparam int SAT = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_alu_control;
    logic [W-1:0]  in_src_a;
    logic [W-1:0]  in_src_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_illegal;
    logic [EW-1:0] err_count;
`ifdef ALU_EXEC_FLAGS_EN
    logic          out_carry;
    logic          out_overflow;
    logic          out_negative;
`endif

    int checks  = 0;
    int errors  = 0;
    int n_out   = 0;
    int err_mdl = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         ill;
        logic         c;
        logic         v;
    } exp_t;

    exp_t exp_q[$];

    alu_exec_stage #(.WIDTH(W), .ERRCNT_W(EW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_control (in_alu_control),
        .in_src_a       (in_src_a),
        .in_src_b       (in_src_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_zero       (out_zero),
        .out_illegal    (out_illegal),
        .err_count      (err_count)
`ifdef ALU_EXEC_FLAGS_EN
        ,
        .out_carry      (out_carry),
        .out_overflow   (out_overflow),
        .out_negative   (out_negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules
    function automatic exp_t ref_alu(input logic [2:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint s;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        e  = '{r: '0, ill: 1'b0, c: 1'b0, v: 1'b0};
        case (op)
            3'd0: begin
                s   = sa + sb;
                e.r = W'(ua + ub);
                e.c = (ua + ub) > 64'sd4294967295;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                s   = sa - sb;
                e.r = W'(ua - ub);
                e.c = ua >= ub;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = (sa < sb) ? W'(1) : W'(0);
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: occupancy, ordering, payload and counter every cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            err_mdl = 0;
        end else begin
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("err_count", err_count, err_mdl);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_out++;
                chk("result", out_result, e.r);
                chk("zero", out_zero, e.r == '0);
                chk("illegal", out_illegal, e.ill);
`ifdef ALU_EXEC_FLAGS_EN
                chk("carry", out_carry, e.c);
                chk("overflow", out_overflow, e.v);
                chk("negative", out_negative, e.r[W-1]);
`endif
            end
            if (in_valid && in_ready) begin
                e = ref_alu(in_alu_control, in_src_a, in_src_b);
                exp_q.push_back(e);
                if (e.ill && err_mdl < SAT) err_mdl++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int n;
        n = 0;
        in_valid       = 1'b1;
        in_alu_control = op;
        in_src_a       = a;
        in_src_b       = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] sp [5];
        sp[0] = '0;
        sp[1] = W'(1);
        sp[2] = '1;
        sp[3] = 32'h7FFF_FFFF;
        sp[4] = 32'h8000_0000;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return W'($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        in_alu_control = '0;
        in_src_a       = '0;
        in_src_b       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", out_result, 0);
        chk("rst_zero", out_zero, 1'b1);
        chk("rst_illegal", out_illegal, 1'b0);
        chk("rst_errcnt", err_count, 0);
`ifdef ALU_EXEC_FLAGS_EN
        chk("rst_flags", {out_carry, out_overflow, out_negative}, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(3'd0, 5, 7);
        chk("add_valid", out_valid, 1'b1);
        chk("add_res", out_result, 12);
        chk("add_zero", out_zero, 1'b0);
        send(3'd1, 7, 7);
        chk("sub_res", out_result, 0);
        chk("sub_zero", out_zero, 1'b1);
        send(3'd2, 32'hF0F0, 32'h0FF0);
        chk("and_res", out_result, 32'h00F0);
        send(3'd3, 32'hF000, 32'h000F);
        chk("or_res", out_result, 32'hF00F);
        send(3'd4, 32'hFFFF_FFFF, 1);
        chk("slt_neg", out_result, 1);
        send(3'd4, 1, 32'hFFFF_FFFF);
        chk("slt_pos", out_result, 0);
        send(3'd4, 3, 3);
        chk("slt_eq", out_result, 0);
        chk("slt_eq_zero", out_zero, 1'b1);
`ifdef ALU_EXEC_FLAGS_EN
        send(3'd0, 32'h7FFF_FFFF, 1);
        chk("f_add_ovf", out_overflow, 1'b1);
        chk("f_add_neg", out_negative, 1'b1);
        chk("f_add_carry", out_carry, 1'b0);
        send(3'd1, 0, 1);
        chk("f_sub_carry0", out_carry, 1'b0);
        chk("f_sub_neg", out_negative, 1'b1);
        send(3'd1, 5, 3);
        chk("f_sub_carry1", out_carry, 1'b1);
`endif
        drain();

        out_ready = 1'b0;
        send(3'd0, 10, 1);
        send(3'd0, 20, 2);
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_first", out_result, 11);
        in_valid       = 1'b1;
        in_alu_control = 3'd1;
        in_src_a       = 30;
        in_src_b       = 3;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_ready", in_ready, 1'b0);
        chk("bp_hold", out_result, 11);
        out_ready = 1'b1;
        send(3'd1, 30, 3);
        drain();

        do_reset();
        send(3'b110, 9, 9);
        chk("ill_flag", out_illegal, 1'b1);
        chk("ill_res", out_result, 0);
        chk("ill_zero", out_zero, 1'b1);
        chk("ill_cnt1", err_count, 1);
        send(3'b101, 1, 2);
        send(3'b111, 3, 4);
        send(3'b110, 5, 6);
        send(3'b101, 7, 8);
        chk("ill_sat", err_count, SAT);
        drain();

        out_ready = 1'b0;
        send(3'd0, 100, 1);
        send(3'd0, 200, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(3'd0, 1, 1);
        chk("post_rst_res", out_result, 2);
        chk("post_rst_errcnt", err_count, 0);
        drain();

        do_reset();
        base = n_out;
        for (int i = 0; i < 600; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_alu_control = 3'($urandom_range(0, 7));
            in_src_a       = rnd_val();
            in_src_b       = rnd_val();
            out_ready      = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();
        chk("rand_activity", (n_out - base) > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
